// File: rtl/uart_tx_if.sv
// Producer-side push handshake for uart_tx: a word plus its valid strobe,
// with back-pressure from the transmit FIFO.
`timescale 1ns/1ps
interface uart_tx_if #(
    parameter int unsigned width = 8
) ();
    logic [width-1:0] data;
    logic             valid;
    logic             can_accept_next_word;

    modport master (
        output data,
        output valid,
        input  can_accept_next_word
    );

    modport slave (
        input  data,
        input  valid,
        output can_accept_next_word
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: small power-of-two FIFO feeding an 8N1-style framer
// (start, width data bits LSB first, one stop bit) with a registered line.
`timescale 1ns/1ps
module uart_tx #(
    parameter int unsigned width      = 8,
    parameter int unsigned baud_rate  = 9600,
    parameter int unsigned clock_freq = 460800,
    parameter int unsigned depth      = 4
) (
    input  logic       clock,
    input  logic       resetn,
    uart_tx_if.slave   bus,
    output logic       signal,
    output logic       busy
);
    localparam int unsigned TICKS = clock_freq / baud_rate;
    localparam int unsigned TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int unsigned BW    = (width > 1) ? $clog2(width) : 1;
    localparam int unsigned AW    = $clog2(depth);
    localparam int unsigned CW    = AW + 1;

    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(width - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(depth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [width-1:0]  shift_q, shift_d;
    logic              line_q, line_d;

    logic [width-1:0]  mem_q [depth];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              push, pop;
    logic              fifo_empty, fifo_full;
    logic [width-1:0]  head;
    logic [width-1:0]  shifted;

    // Full/empty come from the registered count only, so a pop on the same
    // edge never frees a slot for a simultaneous push.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = bus.valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q];
    assign shifted    = shift_q >> 1;

    assign bus.can_accept_next_word = !fifo_full;
    assign signal = line_q;
    assign busy   = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        line_d  = line_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tick_d  = '0;
                    bit_d   = '0;
                    line_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick_q == LAST_TICK) begin
                    tick_d  = '0;
                    line_d  = shift_q[0];
                    state_d = DATA;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            DATA: begin
                if (tick_q == LAST_TICK) begin
                    tick_d = '0;
                    if (bit_q == LAST_BIT) begin
                        line_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shifted;
                        line_d  = shifted[0];
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            STOP: begin
                if (tick_q == LAST_TICK) begin
                    tick_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        bit_d   = '0;
                        line_d  = 1'b0;
                        state_d = START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                line_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            line_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            line_q   <= line_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at default parameters (48 clocks per bit):
// exact line timing, FIFO fill/drop, async reset and a decoded loopback.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int T = 48;

    logic clock = 1'b0;
    logic resetn;
    logic signal;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] rx_q [$];
    bit         mon_en = 1'b1;

    uart_tx_if #(.width(8)) bus ();

    uart_tx #(
        .width(8),
        .baud_rate(9600),
        .clock_freq(460800),
        .depth(4)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus),
        .signal(signal),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Receiver model: samples mid-bit, queues {frame_ok, data}.
    initial begin
        logic [7:0] v;
        logic       ok;
        forever begin
            @(negedge clock);
            if (mon_en && resetn === 1'b1 && signal === 1'b0) begin
                repeat (T/2) @(negedge clock);
                ok = (signal === 1'b0);
                for (int b = 0; b < 8; b++) begin
                    repeat (T) @(negedge clock);
                    v[b] = signal;
                end
                repeat (T) @(negedge clock);
                ok = ok && (signal === 1'b1);
                rx_q.push_back({ok, v});
            end
        end
    end

    task automatic wait_idle(output bit timed_out);
        int n = 0;
        while (busy !== 1'b0 && n < 6000) begin
            @(negedge clock);
            n++;
        end
        timed_out = (busy !== 1'b0);
    endtask

    task automatic test_reset;
        int bad = 0;
        bit to;
        resetn = 1'b0;
        bus.valid = 1'b0;
        bus.data = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (signal !== 1'b1) begin errors++; $display("FAIL rst_signal got %b exp 1", signal); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++;
        if (bus.can_accept_next_word !== 1'b1) begin
            errors++; $display("FAIL rst_accept got %b exp 1", bus.can_accept_next_word);
        end
        resetn = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (signal !== 1'b1 || busy !== 1'b0 || bus.can_accept_next_word !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_100 got %0d bad cycles exp 0", bad); end
        resetn = 1'b0;
        @(negedge clock);
        rx_q.delete();
        resetn = 1'b1;
        bus.data = 8'h96;
        bus.valid = 1'b1;
        @(negedge clock);
        bus.valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL first_push_busy got %b exp 1", busy); end
        wait_idle(to);
        checks++;
        if (to) begin errors++; $display("FAIL first_push_timeout got busy exp idle"); end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 9'h196) begin
            errors++; $display("FAIL first_push_rx got n=%0d w=%h exp n=1 w=196",
                               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
        end
    endtask

    task automatic test_single_frame;
        logic [9:0] fb;
        int         bad [10];
        logic       busy_last;
        fb = {1'b1, 8'hA5, 1'b0};
        foreach (bad[k]) bad[k] = 0;
        @(negedge clock);
        bus.data = 8'hA5;
        bus.valid = 1'b1;
        @(negedge clock);
        bus.valid = 1'b0;
        checks++;
        if (signal !== 1'b1) begin errors++; $display("FAIL a5_latency got %b exp 1", signal); end
        busy_last = 1'b0;
        for (int c = 0; c < 10*T; c++) begin
            @(negedge clock);
            if (signal !== fb[c/T]) bad[c/T]++;
            busy_last = busy;
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bad[k] != 0) begin
                errors++; $display("FAIL a5_bit%0d got %0d wrong cycles exp 0 (level %b)", k, bad[k], fb[k]);
            end
        end
        checks++;
        if (busy_last !== 1'b1) begin errors++; $display("FAIL a5_busy_last got %b exp 1", busy_last); end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || signal !== 1'b1) begin
            errors++; $display("FAIL a5_end got busy=%b sig=%b exp busy=0 sig=1", busy, signal);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] fb;
        int         bad = 0;
        int         j;
        @(negedge clock);
        bus.data = 8'h00;
        bus.valid = 1'b1;
        @(negedge clock);
        bus.data = 8'hFF;
        checks++;
        if (signal !== 1'b1) begin errors++; $display("FAIL b2b_latency got %b exp 1", signal); end
        for (int c = 0; c < 20*T; c++) begin
            @(negedge clock);
            if (c == 0) bus.valid = 1'b0;
            j = c % (10*T);
            fb = (c < 10*T) ? {1'b1, 8'h00, 1'b0} : {1'b1, 8'hFF, 1'b0};
            if (signal !== fb[j/T]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL b2b_stream got %0d wrong cycles exp 0", bad); end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end got busy=%b exp 0", busy); end
    endtask

    task automatic test_fifo_full;
        bit to;
        rx_q.delete();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (i == 5) begin
                checks++;
                if (bus.can_accept_next_word !== 1'b1) begin
                    errors++; $display("FAIL full_acc3 got %b exp 1", bus.can_accept_next_word);
                end
            end
            if (i == 6) begin
                checks++;
                if (bus.can_accept_next_word !== 1'b0) begin
                    errors++; $display("FAIL full_acc4 got %b exp 0", bus.can_accept_next_word);
                end
            end
            bus.data = 8'(i);
            bus.valid = 1'b1;
        end
        @(negedge clock);
        bus.valid = 1'b0;
        checks++;
        if (bus.can_accept_next_word !== 1'b0) begin
            errors++; $display("FAIL full_after_drop got %b exp 0", bus.can_accept_next_word);
        end
        wait_idle(to);
        checks++;
        if (to) begin errors++; $display("FAIL full_timeout got busy exp idle"); end
        checks++;
        if (rx_q.size() != 5) begin errors++; $display("FAIL full_count got %0d exp 5", rx_q.size()); end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {1'b1, 8'(i + 1)}) begin
                errors++; $display("FAIL full_word%0d got %h exp %h", i, rx_q[i], {1'b1, 8'(i + 1)});
            end
        end
    endtask

    task automatic test_reset_midframe;
        int   waits [2];
        logic pre_exp;
        int   bad;
        bit   to;
        waits[0] = 200;
        waits[1] = 60;
        for (int w = 0; w < 2; w++) begin
            pre_exp = (w == 0) ? 1'b1 : 1'b0;
            @(negedge clock);
            bus.data = 8'h3C;
            bus.valid = 1'b1;
            @(negedge clock);
            bus.data = 8'h11;
            @(negedge clock);
            bus.data = 8'h22;
            @(negedge clock);
            bus.valid = 1'b0;
            repeat (waits[w]) @(negedge clock);
            checks++;
            if (signal !== pre_exp) begin
                errors++; $display("FAIL rstmid%0d_pre got %b exp %b", w, signal, pre_exp);
            end
            #2 resetn = 1'b0;
            #1;
            checks++;
            if (signal !== 1'b1 || busy !== 1'b0 || bus.can_accept_next_word !== 1'b1) begin
                errors++; $display("FAIL rstmid%0d_async got sig=%b busy=%b acc=%b exp 1 0 1",
                                   w, signal, busy, bus.can_accept_next_word);
            end
            @(negedge clock);
            resetn = 1'b1;
            bad = 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clock);
                if (signal !== 1'b1 || busy !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rstmid%0d_quiet got %0d bad cycles exp 0", w, bad); end
            rx_q.delete();
            @(negedge clock);
            bus.data = 8'h5A;
            bus.valid = 1'b1;
            @(negedge clock);
            bus.valid = 1'b0;
            wait_idle(to);
            checks++;
            if (to || rx_q.size() != 1 || rx_q[0] !== 9'h15A) begin
                errors++; $display("FAIL rstmid%0d_after got to=%b n=%0d w=%h exp to=0 n=1 w=15a",
                                   w, to, rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
            end
        end
    endtask

    task automatic test_loopback;
        logic [7:0] vals [48];
        int         idx = 0;
        int         cyc = 0;
        bit         to;
        for (int i = 0; i < 48; i++) vals[i] = 8'((i * 53 + 7) % 256);
        vals[46] = 8'h00;
        vals[47] = 8'hFF;
        rx_q.delete();
        while (idx < 48 && cyc < 48*10*T + 2000) begin
            @(negedge clock);
            if (bus.can_accept_next_word === 1'b1) begin
                bus.data = vals[idx];
                bus.valid = 1'b1;
                idx++;
            end else begin
                bus.valid = 1'b0;
            end
            cyc++;
        end
        @(negedge clock);
        bus.valid = 1'b0;
        checks++;
        if (idx != 48) begin errors++; $display("FAIL loop_pushed got %0d exp 48", idx); end
        wait_idle(to);
        checks++;
        if (to || rx_q.size() != 48) begin
            errors++; $display("FAIL loop_count got to=%b n=%0d exp to=0 n=48", to, rx_q.size());
        end
        for (int i = 0; i < 48 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {1'b1, vals[i]}) begin
                errors++; $display("FAIL loop_word%0d got %h exp %h", i, rx_q[i], {1'b1, vals[i]});
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        bus.valid = 1'b0;
        bus.data = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_reset_midframe();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL take parameter width, default 8, meaning data bits per frame.
REQ-002 The block SHALL take parameter baud_rate, default 9600, meaning line bit rate in bits/s.
REQ-003 The block SHALL take parameter clock_freq, default 460800, meaning clock frequency in Hz; ticks_per_bit = clock_freq / baud_rate (integer division, 48 at defaults).
REQ-004 The block SHALL take parameter depth, default 4, meaning transmit FIFO capacity in words; a power of two, at least 2.
REQ-005 The block SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-007 The block SHALL have port data  input  width  word to transmit, sampled when a push occurs.
REQ-008 The block SHALL have port valid  input  1  producer requests a push of data.
REQ-009 The block SHALL have port can_accept_next_word  output  1  high when the FIFO is not full.
REQ-010 The block SHALL have port signal  output  1  serial line, idle high.
REQ-011 The block SHALL have port busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-012 Push SHALL occur on a rising edge where valid=1 and can_accept_next_word=1; valid while full is ignored, with no FIFO change and no error flag.
REQ-013 can_accept_next_word SHALL be decoded from the registered FIFO count (count != depth); a pop in the same cycle SHALL NOT enable a push into a full FIFO.
REQ-014 FIFO SHALL be first-in first-out; pointers wrap modulo depth; count ranges 0..depth.
REQ-015 Transmit FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: signal=1; on an edge with FIFO non-empty, pop the head word into the shift register, clear the bit counter and tick counter, go to START.
REQ-017 START: signal=0 for exactly ticks_per_bit cycles, then DATA.
REQ-018 DATA: bits sent LSB first, each held exactly ticks_per_bit cycles; after bit width-1, go to STOP.
REQ-019 STOP: signal=1 for exactly ticks_per_bit cycles; at the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-020 One frame SHALL occupy exactly (width+2)*ticks_per_bit cycles (480 at defaults).
REQ-021 Latency: a word pushed at edge N into an empty FIFO while IDLE SHALL drive signal low from edge N+1.
REQ-022 A push and a pop on the same edge SHALL both take effect; count unchanged, and the popped word is the old head.
REQ-023 A push into an empty FIFO on the same edge as the STOP-to-next decision SHALL NOT be popped on that edge; it is popped on the next IDLE edge.
REQ-024 signal SHALL be driven from a register (glitch-free).
REQ-025 busy SHALL be registered or decoded from registered state, and be 0 only when FSM=IDLE and count=0.

Reset
REQ-026 While resetn=0: signal=1, busy=0, can_accept_next_word=1, FIFO count=0, pointers=0, FSM=IDLE, counters=0.
REQ-027 Reset asserted mid-frame SHALL force signal=1 asynchronously, abort the frame, and discard all FIFO contents; no partial frame resumes after release.
REQ-028 The first push SHALL be accepted on the first rising edge after resetn deasserts.

Verification
REQ-029 Reset, then hold valid=0 for 100 cycles -> signal=1, busy=0, can_accept_next_word=1 throughout.
REQ-030 Push 0xA5 once -> line carries 0,1,0,1,0,0,1,0,1,1, each level exactly 48 cycles, first low on the cycle after the push; busy falls after 480 cycles.
REQ-031 Push 0x00 and 0xFF on consecutive cycles -> two frames totalling 960 cycles with no high gap between the first stop bit and the second start bit.
REQ-032 Push 0x01..0x06 on 6 consecutive cycles while IDLE -> the first is popped at once; 0x02..0x05 fill the FIFO, can_accept_next_word=0, 0x06 is dropped; line carries 0x01..0x05 only.
REQ-033 Assert resetn=0 during the DATA bit 3 of 0x3C with 2 words queued -> signal=1 immediately; after release, no frame transmits until a new push.
REQ-034 Loopback into uart_rx at the same parameters for all 256 values, pushed whenever can_accept_next_word=1 -> every received word equals the sent word, in order.
